// File: rtl/regfile_writeback.sv
// Register-file writeback arbiter: ALU results own the write port, LSU results
// bypass or queue in a DEPTH-entry FIFO. Define WB_FWD_EN to drive the o_fwd_* copies.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_alu_valid,
  input  logic [4:0]                 i_alu_rd,
  input  logic [31:0]                i_alu_data,
  input  logic                       i_lsu_valid,
  output logic                       o_lsu_ready,
  input  logic [4:0]                 i_lsu_rd,
  input  logic [31:0]                i_lsu_data,
  output logic                       o_RegWrite,
  output logic [4:0]                 o_write_adr,
  output logic [31:0]                o_write_data,
  output logic [$clog2(DEPTH):0]     o_lsu_pending,
  output logic                       o_fwd_valid,
  output logic [4:0]                 o_fwd_adr,
  output logic [31:0]                o_fwd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    rd_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic          we_q, we_d;
  logic [4:0]    adr_q, adr_d;
  logic [31:0]   data_q, data_d;

  logic alu_take_s, lsu_fire_s, fifo_empty_s, pop_s, push_s, bypass_s, ready_s;

  // Ready comes from the registered count only, so no valid-to-ready path exists.
  assign ready_s      = (count_q < CW'(DEPTH));
  assign fifo_empty_s = (count_q == {CW{1'b0}});
  assign alu_take_s   = i_alu_valid && (i_alu_rd != 5'd0);
  assign lsu_fire_s   = i_lsu_valid && ready_s;
  assign pop_s        = !alu_take_s && !fifo_empty_s;
  assign bypass_s     = !alu_take_s && fifo_empty_s && lsu_fire_s && (i_lsu_rd != 5'd0);
  assign push_s       = lsu_fire_s && (i_lsu_rd != 5'd0) && !bypass_s;

  always_comb begin
    we_d     = 1'b0;
    adr_d    = adr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (alu_take_s) begin
      we_d   = 1'b1;
      adr_d  = i_alu_rd;
      data_d = i_alu_data;
    end else if (pop_s) begin
      we_d   = 1'b1;
      adr_d  = rd_mem[rd_ptr_q];
      data_d = data_mem[rd_ptr_q];
    end else if (bypass_s) begin
      we_d   = 1'b1;
      adr_d  = i_lsu_rd;
      data_d = i_lsu_data;
    end else begin
      we_d   = 1'b0;
    end
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q     <= 1'b0;
      adr_q    <= 5'd0;
      data_q   <= 32'd0;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      we_q     <= we_d;
      adr_q    <= adr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage is pure datapath; validity is tracked by the pointers and count.
  always_ff @(posedge i_clk) begin
    if (push_s) begin
      rd_mem[wr_ptr_q]   <= i_lsu_rd;
      data_mem[wr_ptr_q] <= i_lsu_data;
    end
  end

  assign o_lsu_ready   = ready_s;
  assign o_RegWrite    = we_q;
  assign o_write_adr   = adr_q;
  assign o_write_data  = data_q;
  assign o_lsu_pending = count_q;

`ifdef WB_FWD_EN
  assign o_fwd_valid = we_q;
  assign o_fwd_adr   = adr_q;
  assign o_fwd_data  = data_q;
`else
  assign o_fwd_valid = 1'b0;
  assign o_fwd_adr   = 5'd0;
  assign o_fwd_data  = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus random traffic, all
// checked against a queue-based model of the writeback priority rules.
module tb_regfile_writeback;
  localparam int DEPTH = 4;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_alu_valid = 1'b0;
  logic [4:0]  i_alu_rd = 5'd0;
  logic [31:0] i_alu_data = 32'd0;
  logic        i_lsu_valid = 1'b0;
  logic        o_lsu_ready;
  logic [4:0]  i_lsu_rd = 5'd0;
  logic [31:0] i_lsu_data = 32'd0;
  logic        o_RegWrite;
  logic [4:0]  o_write_adr;
  logic [31:0] o_write_data;
  logic [2:0]  o_lsu_pending;
  logic        o_fwd_valid;
  logic [4:0]  o_fwd_adr;
  logic [31:0] o_fwd_data;

  regfile_writeback #(.DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_lsu_valid(i_lsu_valid), .o_lsu_ready(o_lsu_ready),
    .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
    .o_RegWrite(o_RegWrite), .o_write_adr(o_write_adr), .o_write_data(o_write_data),
    .o_lsu_pending(o_lsu_pending),
    .o_fwd_valid(o_fwd_valid), .o_fwd_adr(o_fwd_adr), .o_fwd_data(o_fwd_data)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pending LSU results and the expected write port.
  logic [36:0] mq[$];
  logic        m_we   = 1'b0;
  logic [4:0]  m_adr  = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic        last_acc;
  logic [36:0] wlog[$];
  int          peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    logic ready_m;
    logic [36:0] e;
    i_alu_valid = av; i_alu_rd = ard; i_alu_data = ad;
    i_lsu_valid = lv; i_lsu_rd = lrd; i_lsu_data = ld;
    @(negedge i_clk);
    ready_m = (mq.size() < DEPTH);
    chk("lsu_ready", {31'd0, o_lsu_ready}, {31'd0, ready_m});
    chk("pending", {29'd0, o_lsu_pending}, mq.size());
    last_acc = lv && ready_m;
    if (av && ard != 5'd0) begin
      m_we = 1'b1; m_adr = ard; m_data = ad;
      if (last_acc && lrd != 5'd0) mq.push_back({lrd, ld});
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_adr = e[36:32]; m_data = e[31:0];
      if (last_acc && lrd != 5'd0) mq.push_back({lrd, ld});
    end else if (last_acc && lrd != 5'd0) begin
      m_we = 1'b1; m_adr = lrd; m_data = ld;
    end else begin
      m_we = 1'b0;
    end
    @(posedge i_clk); #1;
    chk("regwrite", {31'd0, o_RegWrite}, {31'd0, m_we});
    chk("write_adr", {27'd0, o_write_adr}, {27'd0, m_adr});
    chk("write_data", o_write_data, m_data);
`ifdef WB_FWD_EN
    chk("fwd_valid", {31'd0, o_fwd_valid}, {31'd0, m_we});
    chk("fwd_adr", {27'd0, o_fwd_adr}, {27'd0, m_adr});
    chk("fwd_data", o_fwd_data, m_data);
`else
    chk("fwd_zero", {26'd0, o_fwd_valid, o_fwd_adr} | o_fwd_data, 32'd0);
`endif
    if (o_RegWrite) wlog.push_back({o_write_adr, o_write_data});
    if (int'(o_lsu_pending) > peak) peak = int'(o_lsu_pending);
  endtask

  initial begin
    logic [4:0] ord [5];
    int k;
    int n_lsu;
    ord[0] = 5'd1; ord[1] = 5'd3; ord[2] = 5'd4; ord[3] = 5'd5; ord[4] = 5'd2;

    #23;
    chk("rst_regwrite", {31'd0, o_RegWrite}, 32'd0);
    chk("rst_adr", {27'd0, o_write_adr}, 32'd0);
    chk("rst_data", o_write_data, 32'd0);
    chk("rst_ready", {31'd0, o_lsu_ready}, 32'd1);
    chk("rst_pending", {29'd0, o_lsu_pending}, 32'd0);
    @(negedge i_clk); i_rst_n = 1'b1;
    repeat (2) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // ALU only, second beat targets x0.
    wlog.delete();
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("alu_adr", {27'd0, o_write_adr}, 32'd5);
    chk("alu_data", o_write_data, 32'hDEADBEEF);
    step(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("alu_rd0_we", {31'd0, o_RegWrite}, 32'd0);

    // LSU bypass.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hCAFE0001);
    chk("byp_we", {31'd0, o_RegWrite}, 32'd1);
    chk("byp_adr", {27'd0, o_write_adr}, 32'd7);
    chk("byp_data", o_write_data, 32'hCAFE0001);
    chk("byp_pending", {29'd0, o_lsu_pending}, 32'd0);

    // Conflict: LSU beat waits behind four ALU beats.
    wlog.delete(); peak = 0;
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'hAA);
    step(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    step(1'b1, 5'd5, 32'h55, 1'b0, 5'd0, 32'd0);
    repeat (2) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("cf_count", wlog.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < wlog.size()) chk("cf_order", {27'd0, wlog[i][36:32]}, {27'd0, ord[i]});
    if (wlog.size() == 5) chk("cf_x2_data", wlog[4][31:0], 32'hAA);
    chk("cf_peak", peak, 32'd1);

    // Fill and backpressure with the ALU busy, then drain.
    wlog.delete(); k = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 5'd10 + 5'(c % 5), 32'h9000 + c, k < 6, 5'd16 + 5'(k), 32'h100 + k);
      if (last_acc) k++;
    end
    chk("fill_accepted", k, 32'd4);
    chk("fill_ready", {31'd0, o_lsu_ready}, 32'd0);
    chk("fill_pending", {29'd0, o_lsu_pending}, 32'd4);
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 5'd0, 32'd0, k < 6, 5'd16 + 5'(k), 32'h100 + k);
      if (last_acc) k++;
    end
    n_lsu = 0;
    foreach (wlog[i]) begin
      if (wlog[i][36:32] >= 5'd16) begin
        chk("drain_adr", {27'd0, wlog[i][36:32]}, 32'd16 + n_lsu);
        chk("drain_data", wlog[i][31:0], 32'h100 + n_lsu);
        n_lsu++;
      end
    end
    chk("drain_count", n_lsu, 32'd6);

    // Reset mid-stream with three queued entries.
    for (int c = 0; c < 3; c++)
      step(1'b1, 5'd20 + 5'(c), 32'h7000 + c, 1'b1, 5'd8 + 5'(c), 32'h8000 + c);
    chk("pre_rst_pending", {29'd0, o_lsu_pending}, 32'd3);
    i_rst_n = 1'b0; #1;
    chk("mid_rst_pending", {29'd0, o_lsu_pending}, 32'd0);
    chk("mid_rst_we", {31'd0, o_RegWrite}, 32'd0);
    chk("mid_rst_ready", {31'd0, o_lsu_ready}, 32'd1);
    mq.delete(); m_we = 1'b0; m_adr = 5'd0; m_data = 32'd0;
    i_alu_valid = 1'b0; i_lsu_valid = 1'b0;
    @(negedge i_clk); i_rst_n = 1'b1;
    wlog.delete();
    repeat (5) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("post_rst_writes", wlog.size(), 32'd0);

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 2) == 0,
           ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Writeback arbiter that drives the register-file write port (write enable, write address, write data) from two result sources: the single-cycle ALU and the multi-cycle load/store unit (LSU). ALU results always win the port. LSU results arrive over a valid/ready handshake and are buffered in a small FIFO until the port is free. The block sits between the execute/memory stages and the register file, and is the only writer of that register file.

## Interface
- DEPTH, 4, LSU result FIFO entries; power of two, at least 2
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_alu_valid  in  1  ALU result present this cycle; there is no ready signal, so it is always consumed
- i_alu_rd  in  5  ALU destination register
- i_alu_data  in  32  ALU result
- i_lsu_valid  in  1  LSU result offered
- o_lsu_ready  out  1  block accepts an LSU result this cycle
- i_lsu_rd  in  5  LSU destination register
- i_lsu_data  in  32  LSU result
- o_RegWrite  out  1  register-file write enable, registered
- o_write_adr  out  5  register-file write address, registered
- o_write_data  out  32  register-file write data, registered
- o_lsu_pending  out  $clog2(DEPTH)+1  LSU FIFO occupancy
- o_fwd_valid  out  1  forwarding copy of o_RegWrite (see Configuration)
- o_fwd_adr  out  5  forwarding copy of o_write_adr
- o_fwd_data  out  32  forwarding copy of o_write_data

## Operation
- The output register (o_RegWrite/adr/data) is loaded every cycle from exactly one source, chosen in priority order:
  1. ALU beat with i_alu_valid=1 and i_alu_rd≠0
  2. FIFO head, if the FIFO is not empty; the head is popped
  3. Bypass: the LSU handshake fires, i_lsu_rd≠0, and the FIFO is empty. The beat goes directly to the output register and is not enqueued.
  4. None of the above: o_RegWrite=0. Address and data hold their previous values.
- An ALU beat with rd=0 is discarded and does not claim the port.
- An LSU handshake (i_lsu_valid & o_lsu_ready) with rd=0 completes normally and is discarded: it is not enqueued and not written.
- An accepted LSU beat with rd≠0 that does not take the bypass path is pushed to the FIFO tail.
- o_lsu_ready = (count < DEPTH). It depends only on registered state, with no combinational path from any valid input.
- When the FIFO is full and popped in the same cycle, o_lsu_ready is still 0 that cycle. A push and a pop in the same cycle leave the count unchanged.
- Pointers wrap modulo DEPTH. The count saturates at neither end because push and pop are both guarded.
- The block does not check register ordering. Issue logic must not have an ALU op and an outstanding LSU op targeting the same rd.
- o_lsu_pending equals the FIFO count.

## Timing
- Reset (asynchronous, i_rst_n=0):
  - o_RegWrite=0, o_write_adr=0, o_write_data=0
  - FIFO empty, o_lsu_pending=0, o_lsu_ready=1
  - o_fwd_* all 0
- Reset asserted mid-operation discards all FIFO contents and any in-flight write. No write issues in the first cycle after release.
- ALU latency: a beat sampled at edge N appears on the outputs after edge N, so the register file captures it at edge N+1.
- LSU latency with an empty FIFO and no ALU beat: same as ALU (one cycle, via bypass).
- LSU latency when blocked by ALU beats: one cycle plus the number of cycles the ALU holds the port plus the number of entries ahead in the FIFO.
- Throughput: one register-file write per cycle maximum. The FIFO drains in order.

## Configuration
- Macro: WB_FWD_EN.
  - Defined: o_fwd_valid/o_fwd_adr/o_fwd_data mirror o_RegWrite/o_write_adr/o_write_data each cycle, for use by the decode-stage forwarding muxes.
  - Undefined: the three o_fwd_* outputs are tied to constant 0 and no extra logic is generated.
- All other behaviour is identical with and without the macro.

## Test plan
- Reset then idle:
  - Outputs: o_RegWrite=0, o_lsu_ready=1, o_lsu_pending=0.
  - Pulse i_rst_n low mid-stream with 3 FIFO entries: o_lsu_pending returns to 0 immediately and none of the 3 writes ever appear.
- ALU only: beats rd=5/0xDEADBEEF then rd=0/0x1234 on consecutive edges.
  - Result: one write of x5=0xDEADBEEF one cycle later, then o_RegWrite=0.
- LSU bypass: single LSU beat rd=7/0xCAFE0001 with the FIFO empty and no ALU.
  - Result: x7 is written one cycle later and o_lsu_pending stays 0.
- Conflict: ALU (rd=1) and LSU (rd=2, 0xAA) in the same cycle, with ALU beats continuing for 3 more cycles (rd=3,4,5).
  - Writes appear in the order x1, x3, x4, x5, x2=0xAA.
  - o_lsu_pending peaks at 1.
- Fill and backpressure: hold the ALU busy while the LSU presents 6 beats (DEPTH=4).
  - After 4 accepts, o_lsu_ready=0. No beat is lost or duplicated.
  - After the ALU idles, the FIFO drains in order and o_lsu_ready rises in the cycle after the first pop.
- WB_FWD_EN: run the conflict scenario with and without the macro.
  - Defined: o_fwd_* match o_RegWrite/o_write_adr/o_write_data every cycle.
  - Undefined: o_fwd_* stay 0.
